// File: rtl/fm_sched_pkg.sv
// Shared state encoding and width constants for the FM phase-increment scheduler.
package fm_sched_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int GAIN_W    = 16;
    localparam int PHASE_W   = 32;
    localparam int DIV_W     = 16;
    localparam int MUL_STEPS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        MUL  = 2'd2,
        HOLD = 2'd3
    } sched_state_t;

endpackage

// File: rtl/fm_seq_mult.sv
// Unsigned shift-add multiplier: start loads the operands, then one partial product per cycle.
// done is high during the cycle whose edge performs the final add.
module fm_seq_mult
    import fm_sched_pkg::*;
#(
    parameter int A_W = SAMPLE_W + 1,
    parameter int B_W = MUL_STEPS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 start,
    input  logic [A_W-1:0]       multiplicand,
    input  logic [B_W-1:0]       multiplier,
    output logic                 done,
    output logic [A_W+B_W-1:0]   product
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(B_W - 1);

    logic             running;
    logic [CNT_W-1:0] step;
    logic [P_W-1:0]   addend;
    logic [B_W-1:0]   bits;

    always_ff @(posedge clock) begin
        if (reset) begin
            running <= 1'b0;
            step    <= '0;
            addend  <= '0;
            bits    <= '0;
            product <= '0;
        end else if (clear) begin
            running <= 1'b0;
            step    <= '0;
        end else if (start) begin
            running <= 1'b1;
            step    <= '0;
            addend  <= P_W'(multiplicand);
            bits    <= multiplier;
            product <= '0;
        end else if (running) begin
            // LSB-first: the multiplicand doubles each step as the multiplier shifts right
            if (bits[0]) begin
                product <= product + addend;
            end
            addend <= addend << 1;
            bits   <= bits >> 1;
            step   <= step + CNT_W'(1);
            if (step == LAST_STEP) begin
                running <= 1'b0;
            end
        end
    end

    assign done = running && (step == LAST_STEP);

endmodule

// File: rtl/fm_phaseinc_sched.sv
// FM phase-increment scheduler: strobe divider, sample FSM and strobe-aligned increment commit.
// Define FM_PHASEINC_SAT_EN to clamp out-of-range sums instead of wrapping them modulo 2^32.
module fm_phaseinc_sched
    import fm_sched_pkg::*;
#(
    parameter int NBITS_SAMPLE = SAMPLE_W,
    parameter int NBITS_GAIN   = GAIN_W,
    parameter int NBITS_PHASE  = PHASE_W,
    parameter int NBITS_DIV    = DIV_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic [NBITS_PHASE-1:0]  carrier_inc,
    input  logic [NBITS_GAIN-1:0]   kdev,
    input  logic [NBITS_DIV-1:0]    clkdiv,
    input  logic [NBITS_SAMPLE-1:0] sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    enableclk,
    output logic [NBITS_PHASE-1:0]  phaseinc,
    output logic                    busy,
    output logic                    ovf
);

    localparam int MAG_W  = NBITS_SAMPLE + 1;
    localparam int PROD_W = MAG_W + NBITS_GAIN;
    localparam int SUM_W  = NBITS_PHASE + 2;

    sched_state_t           state;
    sched_state_t           state_next;
    logic [NBITS_DIV-1:0]   divcnt;
    logic [MAG_W-1:0]       sample_ext;
    logic [MAG_W-1:0]       sample_mag;
    logic                   sample_neg;
    logic                   mult_start;
    logic                   mult_done;
    logic [PROD_W-1:0]      mult_mag;
    logic [PROD_W-1:0]      product;
    logic [SUM_W-1:0]       product_ext;
    logic [SUM_W-1:0]       sum;
    logic                   commit;
    logic                   commit_ovf;
    logic [NBITS_PHASE-1:0] commit_val;

    always_ff @(posedge clock) begin
        if (reset) begin
            divcnt    <= '0;
            enableclk <= 1'b0;
        end else if (!run) begin
            divcnt    <= '0;
            enableclk <= 1'b0;
        end else if (divcnt == '0) begin
            divcnt    <= clkdiv;
            enableclk <= 1'b1;
        end else begin
            divcnt    <= divcnt - NBITS_DIV'(1);
            enableclk <= 1'b0;
        end
    end

    // One extra magnitude bit so that the most negative sample still has a representable magnitude
    assign sample_ext = {sample_in[NBITS_SAMPLE-1], sample_in};
    assign sample_mag = sample_ext[MAG_W-1] ? (~sample_ext + MAG_W'(1)) : sample_ext;

    fm_seq_mult #(
        .A_W (MAG_W),
        .B_W (NBITS_GAIN)
    ) u_mult (
        .clock        (clock),
        .reset        (reset),
        .clear        (!run),
        .start        (mult_start),
        .multiplicand (sample_mag),
        .multiplier   (kdev),
        .done         (mult_done),
        .product      (mult_mag)
    );

    assign product     = sample_neg ? (~mult_mag + PROD_W'(1)) : mult_mag;
    assign product_ext = SUM_W'($signed(product));
    assign sum         = SUM_W'(carrier_inc) + product_ext;
    assign commit_ovf  = sum[SUM_W-1] | sum[SUM_W-2];

    always_comb begin
`ifdef FM_PHASEINC_SAT_EN
        if (sum[SUM_W-1]) begin
            commit_val = '0;
        end else if (sum[SUM_W-2]) begin
            commit_val = '1;
        end else begin
            commit_val = sum[NBITS_PHASE-1:0];
        end
`else
        commit_val = sum[NBITS_PHASE-1:0];
`endif
    end

    always_comb begin
        state_next = state;
        mult_start = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (sample_valid) begin
                    state_next = MUL;
                    mult_start = 1'b1;
                end
            end
            MUL: begin
                if (mult_done) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // Commit on the strobe edge itself: the DDS consumes the old increment on this strobe
                if (enableclk) begin
                    state_next = WAIT;
                    commit     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!run) begin
            state_next = IDLE;
            mult_start = 1'b0;
            commit     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sample_neg <= 1'b0;
            phaseinc   <= '0;
            ovf        <= 1'b0;
        end else begin
            state <= state_next;
            if (mult_start) begin
                sample_neg <= sample_in[NBITS_SAMPLE-1];
            end
            if (state == IDLE || !run) begin
                phaseinc <= carrier_inc;
            end else if (commit) begin
                phaseinc <= commit_val;
                ovf      <= commit_ovf;
            end
        end
    end

    assign sample_ready = (state == WAIT);
    assign busy         = (state == MUL) || (state == HOLD);

endmodule

// File: tb/tb_fm_phaseinc_sched.sv
// Self-checking bench for fm_phaseinc_sched: vector table, scoreboard of pending commits, corner sequences.
// Expected commit values follow FM_PHASEINC_SAT_EN when that macro is defined for the build.
module tb_fm_phaseinc_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] carrier_inc;
    logic [15:0] kdev;
    logic [15:0] clkdiv;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        enableclk;
    logic [31:0] phaseinc;
    logic        busy;
    logic        ovf;

    always #5 clock = ~clock;

    fm_phaseinc_sched dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .carrier_inc  (carrier_inc),
        .kdev         (kdev),
        .clkdiv       (clkdiv),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .enableclk    (enableclk),
        .phaseinc     (phaseinc),
        .busy         (busy),
        .ovf          (ovf)
    );

    typedef struct {
        logic [31:0] carrier;
        logic [15:0] kdev;
        logic [15:0] sample;
        logic [15:0] clkdiv;
        logic [31:0] exp_wrap;
        logic [31:0] exp_sat;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] val;
        logic        ovf;
        int          hs_cycle;
        int          div;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;
    int          cycle_no = 0;
    int          commits = 0;
    logic [31:0] exp_next_val;
    logic        exp_next_ovf;
    logic        last_ovf;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] c, input logic [15:0] k, input logic [15:0] s);
        longint ls, lk, lc, total;
        logic   o;
        logic [31:0] v;
        ls    = $signed(s);
        lk    = {48'd0, k};
        lc    = {32'd0, c};
        total = ls * lk + lc;
        o     = (total < 0) || (total > 64'sd4294967295);
`ifdef FM_PHASEINC_SAT_EN
        if (total < 0) v = 32'h0000_0000;
        else if (o)    v = 32'hFFFF_FFFF;
        else           v = total[31:0];
`else
        v = total[31:0];
`endif
        return {o, v};
    endfunction

    // One clock: inputs were set at the previous negedge, outputs are examined at the next negedge
    task automatic tick();
        logic hs_pre, busy_pre, run_pre, reset_pre, en_pre;
        exp_t e;
        int   lat;
        hs_pre    = sample_valid && sample_ready;
        busy_pre  = busy;
        run_pre   = run;
        reset_pre = reset;
        en_pre    = enableclk;
        @(negedge clock);
        cycle_no++;
        if (reset_pre || !run_pre) begin
            sb.delete();
        end else begin
            if (busy_pre && !busy) begin
                commits++;
                check_output("commit_on_strobe", en_pre, 1);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_commit: actual=commit with phaseinc %0h required=no commit", phaseinc);
                end else begin
                    e = sb.pop_front();
                    check_output("phaseinc", phaseinc, e.val);
                    check_output("ovf", ovf, e.ovf);
                    last_ovf = e.ovf;
                    lat = cycle_no - e.hs_cycle;
                    checks++;
                    if (lat < 17 || lat > 17 + e.div) begin
                        errors++;
                        $display("[TB] FAIL latency: actual=%0d cycles required=17..%0d", lat, 17 + e.div);
                    end
                end
            end
            if (hs_pre) begin
                sb.push_back('{exp_next_val, exp_next_ovf, cycle_no, int'(clkdiv)});
            end
        end
    endtask

    task automatic send_sample(input logic [15:0] s, input logic [31:0] ev, input logic ev_ovf);
        int n;
        n            = 0;
        sample_in    = s;
        exp_next_val = ev;
        exp_next_ovf = ev_ovf;
        sample_valid = 1'b1;
        while (!sample_ready && n < 100) begin
            tick();
            n++;
        end
        check_output("handshake_timeout", sample_ready, 1);
        if (sample_ready) begin
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_commits();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        check_output("commit_timeout", sb.size(), 0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        carrier_inc = v.carrier;
        kdev        = v.kdev;
        clkdiv      = v.clkdiv;
`ifdef FM_PHASEINC_SAT_EN
        send_sample(v.sample, v.exp_sat, v.exp_ovf);
`else
        send_sample(v.sample, v.exp_wrap, v.exp_ovf);
`endif
        wait_commits();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   accepted, n, commits_before, hs_c;
        logic hs, found;
        vec_t v;

        vecs[0] = '{32'h0100_0000, 16'h0100, 16'h0010, 16'd3, 32'h0100_1000, 32'h0100_1000, 1'b0};
        vecs[1] = '{32'h0100_0000, 16'hFFFF, 16'h8000, 16'd3, 32'h8100_8000, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'hFFFF_0000, 16'h0004, 16'h7FFF, 16'd1, 32'h0000_FFFC, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{32'h2000_0000, 16'h1234, 16'hFFFF, 16'd5, 32'h1FFF_EDCC, 32'h1FFF_EDCC, 1'b0};
        vecs[4] = '{32'h0000_0000, 16'h0001, 16'hFFFF, 16'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_0010, 16'h0000, 16'h8000, 16'd2, 32'h0000_0010, 32'h0000_0010, 1'b0};
        vecs[6] = '{32'h7FFF_FFFF, 16'hFFFF, 16'h7FFF, 16'd7, 32'hFFFE_8000, 32'hFFFE_8000, 1'b0};
        vecs[7] = '{32'h8000_0000, 16'h0002, 16'hC000, 16'd4, 32'h7FFF_8000, 32'h7FFF_8000, 1'b0};

        reset        = 1'b1;
        run          = 1'b0;
        carrier_inc  = 32'h0;
        kdev         = 16'h0;
        clkdiv       = 16'h0;
        sample_in    = 16'h0;
        sample_valid = 1'b0;
        exp_next_val = 32'h0;
        exp_next_ovf = 1'b0;
        last_ovf     = 1'b0;
        tick();
        tick();
        check_output("reset_sample_ready", sample_ready, 0);
        check_output("reset_enableclk", enableclk, 0);
        check_output("reset_phaseinc", phaseinc, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_ovf", ovf, 0);

        reset       = 1'b0;
        carrier_inc = 32'h1234_5678;
        tick();
        check_output("idle_phaseinc", phaseinc, 32'h1234_5678);
        check_output("idle_ready", sample_ready, 0);

        $display("[TB] divider period with clkdiv=3");
        run    = 1'b1;
        clkdiv = 16'd3;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_output("enableclk_period", enableclk, (i % 4 == 0));
            if (i == 0) check_output("wait_ready", sample_ready, 1);
        end

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
        end

        $display("[TB] back-to-back with sample_valid held high, clkdiv=0");
        clkdiv         = 16'd0;
        carrier_inc    = 32'h4000_0000;
        kdev           = 16'($urandom);
        sample_in      = 16'($urandom);
        {exp_next_ovf, exp_next_val} = model(carrier_inc, kdev, sample_in);
        sample_valid   = 1'b1;
        accepted       = 0;
        n              = 0;
        commits_before = commits;
        while (accepted < 3 && n < 200) begin
            hs = sample_valid && sample_ready;
            tick();
            n++;
            check_output("ready_while_busy", sample_ready && busy, 0);
            if (hs) begin
                accepted++;
                sample_in = 16'($urandom);
                {exp_next_ovf, exp_next_val} = model(carrier_inc, kdev, sample_in);
            end
        end
        sample_valid = 1'b0;
        wait_commits();
        check_output("b2b_accepted", accepted, 3);
        check_output("b2b_commits", commits - commits_before, 3);

        $display("[TB] run dropped during MUL");
        clkdiv      = 16'd2;
        carrier_inc = 32'h0100_0000;
        kdev        = 16'h0100;
        send_sample(16'h0010, 32'h0100_1000, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check_output("mul_busy", busy, 1);
        commits_before = commits;
        run         = 1'b0;
        carrier_inc = 32'h0A0B_0C0D;
        tick();
        check_output("drop_busy", busy, 0);
        check_output("drop_ready", sample_ready, 0);
        check_output("drop_enableclk", enableclk, 0);
        check_output("drop_phaseinc", phaseinc, 32'h0A0B_0C0D);
        for (int i = 0; i < 25; i++) tick();
        check_output("drop_no_commit_phaseinc", phaseinc, 32'h0A0B_0C0D);
        check_output("drop_ovf_kept", ovf, last_ovf);
        check_output("drop_no_commit", commits - commits_before, 0);

        $display("[TB] reset asserted in HOLD");
        run      = 1'b1;
        v        = vecs[1];
        v.clkdiv = 16'd7;
        apply_stimulus(v);
        kdev = 16'h0100;
        send_sample(16'h0010, 32'h0100_1000, 1'b0);
        hs_c  = cycle_no;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if ((cycle_no - hs_c) >= 16 && busy && !enableclk) found = 1'b1;
            else tick();
        end
        check_output("reach_hold", found, 1);
        reset = 1'b1;
        tick();
        check_output("hold_reset_ready", sample_ready, 0);
        check_output("hold_reset_enableclk", enableclk, 0);
        check_output("hold_reset_phaseinc", phaseinc, 0);
        check_output("hold_reset_busy", busy, 0);
        check_output("hold_reset_ovf", ovf, 0);
        reset = 1'b0;
        run   = 1'b0;
        tick();
        check_output("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fm_phaseinc_sched.md
Name: fm_phaseinc_sched

Overview:
- Controller feeding a DDS phase accumulator (clock-enable + 32-bit phase increment inputs) for FM modulation.
- Accepts signed audio samples through a valid/ready handshake.
- Computes phaseinc = carrier_inc + sample*kdev with a 16-step sequential shift-add multiplier.
- Generates the DDS enableclk strobe from a programmable divider and commits each new increment only at a strobe boundary, so the DDS never sees a mid-interval change.

Parameters:
NBITS_SAMPLE, 16, audio sample width (signed two's complement)
NBITS_GAIN, 16, deviation gain width (unsigned)
NBITS_PHASE, 32, phase increment width
NBITS_DIV, 16, enable divider width

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  1 = modulate; 0 = idle, output carrier only
carrier_inc  input  NBITS_PHASE  unmodulated carrier increment
kdev  input  NBITS_GAIN  deviation gain
clkdiv  input  NBITS_DIV  strobe period minus 1
sample_in  input  NBITS_SAMPLE  signed audio sample
sample_valid  input  1  sample_in valid
sample_ready  output  1  controller can accept a sample
enableclk  output  1  one-cycle DDS advance strobe
phaseinc  output  NBITS_PHASE  increment to DDS (registered)
busy  output  1  state is MUL or HOLD
ovf  output  1  sticky: last committed sum wrapped or saturated

Behaviour:
- Reset values: sample_ready=0, enableclk=0, phaseinc=0, busy=0, ovf=0, state=IDLE, divcnt=0, product=0.
- Divider:
  - divcnt counts down while run=1.
  - enableclk=1 (registered) for the cycle after divcnt reaches 0; divcnt then reloads clkdiv.
  - Period is clkdiv+1 cycles. clkdiv=0 gives enableclk high every cycle.
  - A clkdiv change takes effect at the next reload.
  - run=0: enableclk=0 and divcnt=0, so the first strobe comes one cycle after run rises.
- FSM states IDLE, WAIT, MUL, HOLD:
  - IDLE: run=0. phaseinc<=carrier_inc every cycle, sample_ready=0. Goes to WAIT when run=1.
  - WAIT: sample_ready=1. A handshake (sample_valid && sample_ready) latches |sample_in| (17-bit, so -32768 is handled), its sign and kdev, then goes to MUL.
  - MUL: exactly 16 cycles of shift-add producing a 33-bit magnitude, negated if the sign is set, giving a signed 33-bit product. Then goes to HOLD.
  - HOLD: result pending. On a cycle with enableclk=1, phaseinc<=carrier_inc+product at that edge, ovf updated, and the state goes to WAIT. The DDS uses the old increment on that strobe and the new one from the next strobe onward.
- Arithmetic:
  - The sum is computed in 34 bits signed, with carrier_inc zero-extended.
  - Result outside [0, 2^32-1]: low 32 bits are committed (modulo wrap) and ovf is set.
  - In-range commit: ovf cleared.
- Latency: handshake to commit is at least 17 cycles, plus the wait for the next strobe.
- Only one sample is outstanding at a time; back-pressure is via sample_ready.
- run falling in any state: next state IDLE, pending result discarded, phaseinc returns to carrier_inc the following cycle.
- reset asserted mid-MUL or in HOLD: all state and outputs return to reset values on the next edge.
- carrier_inc changes are only picked up at commit time, or in IDLE.

Optional Feature:
- Macro FM_PHASEINC_SAT_EN.
- Defined: out-of-range sums clamp. Negative sums commit 0x00000000; sums above the maximum commit 0xFFFFFFFF. ovf is set in both cases.
- Undefined: modulo wrap as described under Behaviour.

Decomposition:
- Package fm_sched_pkg holds:
  - FSM state encoding (IDLE=0, WAIT=1, MUL=2, HOLD=3)
  - MUL_STEPS=16
  - width constants for the sample, gain and phase
- One natural sub-module: fm_seq_mult, a 16-step unsigned shift-add multiplier with start/done handshake; sign handling stays in the parent.

Test Plan:
- Reset, then run=1, clkdiv=3 -> enableclk pulses exactly every 4 cycles; sample_ready=1 in WAIT.
- carrier_inc=0x01000000, kdev=0x0100, sample=0x0010 -> phaseinc=0x01001000 committed on the strobe cycle edge; ovf=0; handshake to commit is at least 17 cycles.
- carrier_inc=0x01000000, kdev=0xFFFF, sample=0x8000 -> product=-0x7FFF8000. Without macro phaseinc=0x81008000, ovf=1; with FM_PHASEINC_SAT_EN phaseinc=0x00000000, ovf=1.
- carrier_inc=0xFFFF0000, kdev=0x0004, sample=0x7FFF -> without macro 0x0000FFFC, ovf=1; with macro 0xFFFFFFFF.
- Drop run during MUL -> IDLE next cycle, phaseinc=carrier_inc, enableclk=0, no commit; assert reset in HOLD -> all outputs zero on the next edge.
- Hold sample_valid=1 continuously with clkdiv=0 -> one sample accepted per commit, sample_ready=0 throughout MUL and HOLD, no sample lost or duplicated.
